// File: rtl/sw_scan_conditioner.sv
// rtl/sw_scan_conditioner.sv - switch/button synchronizer, debouncer, press strobes and digit-scan divider
//
// Ports:
//   clk        rising-edge system clock for all state
//   rst        asynchronous active-high reset
//   SW_raw     [7:0] asynchronous slide switches
//   BTN_raw    [3:0] asynchronous push buttons, active-high
//   SW_OK      [7:0] debounced switch levels
//   BTN_OK     [3:0] debounced button levels
//   btn_pulse  [3:0] one-cycle strobe on each debounced button press
//   scanning   [1:0] seven-segment digit-scan index (top two divider bits)
module sw_scan_conditioner #(
    parameter int DEB_LIMIT = 50000,
    parameter int SCAN_W    = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        SW_raw,
    input  logic [3:0]        BTN_raw,
    output logic [7:0]        SW_OK,
    output logic [3:0]        BTN_OK,
    output logic [3:0]        btn_pulse,
    output logic [1:0]        scanning
);

    localparam int            NCH     = 12;
    localparam logic [15:0]   CNT_MAX = 16'(DEB_LIMIT - 1);

    // Channel map: [7:0] switches, [11:8] buttons.
    logic [NCH-1:0]           raw;
    logic [NCH-1:0]           sync1_q;
    logic [NCH-1:0]           sync2_q;
    logic [NCH-1:0]           ok_q;
    logic [NCH-1:0]           ok_d;
    logic [NCH-1:0][15:0]     cnt_q;
    logic [NCH-1:0][15:0]     cnt_d;
    logic [3:0]               pulse_q;
    logic [SCAN_W-1:0]        div_q;

    assign raw = {BTN_raw, SW_raw};

    // A channel counts only while its synchronized level disagrees with the
    // accepted level; any agreement (including a glitch back) restarts at 0.
    always_comb begin
        ok_d  = ok_q;
        cnt_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sync2_q[i] != ok_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ok_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            ok_q    <= '0;
            cnt_q   <= '0;
            pulse_q <= '0;
            div_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            ok_q    <= ok_d;
            cnt_q   <= cnt_d;
            // Registered rising-edge detect so the strobe lines up with BTN_OK.
            pulse_q <= ok_d[11:8] & ~ok_q[11:8];
            div_q   <= div_q + 1'b1;
        end
    end

    assign SW_OK     = ok_q[7:0];
    assign BTN_OK    = ok_q[11:8];
    assign btn_pulse = pulse_q;
    assign scanning  = div_q[SCAN_W-1 -: 2];

endmodule

// File: tb/tb_sw_scan_conditioner.sv
// tb/tb_sw_scan_conditioner.sv - scoreboard bench for sw_scan_conditioner
module tb_sw_scan_conditioner;

    localparam int DEB = 4;
    localparam int SW  = 4;
    localparam int LAT = 2 + DEB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] SW_raw  = '0;
    logic [3:0] BTN_raw = '0;
    logic [7:0] SW_OK;
    logic [3:0] BTN_OK;
    logic [3:0] btn_pulse;
    logic [1:0] scanning;

    sw_scan_conditioner #(.DEB_LIMIT(DEB), .SCAN_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .SW_raw    (SW_raw),
        .BTN_raw   (BTN_raw),
        .SW_OK     (SW_OK),
        .BTN_OK    (BTN_OK),
        .btn_pulse (btn_pulse),
        .scanning  (scanning)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;
        logic [15:0] v;
    } evt_t;

    evt_t        evq[$];
    int          cyc       = 0;
    int          scan_base = 0;
    int          n_checks  = 0;
    int          n_fail    = 0;
    logic [15:0] prev_obs  = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic expect_at(input int c, input logic [7:0] s, input logic [3:0] b, input logic [3:0] p);
        evt_t e;
        e.c = c;
        e.v = {s, b, p};
        evq.push_back(e);
    endtask

    // Drive point is 2 time units after a rising edge; the next edge is the
    // first sampling edge, and the output changes on the LAT-th edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Monitor on the falling edge: every output change must match the next
    // scheduled event in both cycle and value; nothing may change unannounced.
    always @(negedge clk) begin
        logic [15:0] cur;
        evt_t        e;
        int          d;
        cur = {SW_OK, BTN_OK, btn_pulse};
        if (cur !== prev_obs) begin
            if (evq.size() == 0) begin
                chk("unexpected_change", {16'd0, cur}, {16'd0, prev_obs});
            end else begin
                e = evq.pop_front();
                chk("evt_cycle", e.c == cyc ? 32'(cyc) : 32'(cyc), 32'(e.c));
                chk("evt_value", {16'd0, cur}, {16'd0, e.v});
            end
        end else if (evq.size() != 0 && evq[0].c <= cyc) begin
            e = evq.pop_front();
            chk("missed_evt", {16'd0, cur}, {16'd0, e.v});
        end
        prev_obs = cur;
        if (rst) begin
            chk("scan_rst", {30'd0, scanning}, 32'd0);
        end else begin
            d = cyc - scan_base;
            chk("scan", {30'd0, scanning}, 32'((d % 16) / 4));
        end
    end

    initial begin
        int n;
        step(3);
        chk("rst_sw_ok",  {24'd0, SW_OK},     32'd0);
        chk("rst_btn_ok", {28'd0, BTN_OK},    32'd0);
        chk("rst_pulse",  {28'd0, btn_pulse}, 32'd0);
        rst = 1'b0;
        scan_base = cyc;
        step(20);

        // Switch word change held steady.
        SW_raw = 8'hA1;
        n = cyc;
        expect_at(n + LAT, 8'hA1, 4'h0, 4'h0);
        step(12);

        // Bouncing button 0: only the final rise counts.
        for (int k = 0; k < 5; k++) begin
            BTN_raw[0] = (k % 2 == 0);
            if (k < 4) step(1);
        end
        n = cyc;
        expect_at(n + LAT,     8'hA1, 4'h1, 4'h1);
        expect_at(n + LAT + 1, 8'hA1, 4'h1, 4'h0);
        step(12);
        BTN_raw = 4'h0;
        n = cyc;
        expect_at(n + LAT, 8'hA1, 4'h0, 4'h0);
        step(12);

        // Long hold on button 2: one pulse, silent release.
        BTN_raw = 4'h4;
        n = cyc;
        expect_at(n + LAT,     8'hA1, 4'h4, 4'h4);
        expect_at(n + LAT + 1, 8'hA1, 4'h4, 4'h0);
        step(50);
        BTN_raw = 4'h0;
        n = cyc;
        expect_at(n + LAT, 8'hA1, 4'h0, 4'h0);
        step(12);

        // Button 1 debounced high before the reset below.
        BTN_raw = 4'h2;
        n = cyc;
        expect_at(n + LAT,     8'hA1, 4'h2, 4'h2);
        expect_at(n + LAT + 1, 8'hA1, 4'h2, 4'h0);
        step(12);

        // Reset while SW_raw[3]'s count is at 2.
        SW_raw = 8'hA9;
        step(4);
        rst = 1'b1;
        expect_at(cyc, 8'h00, 4'h0, 4'h0);
        step(3);
        rst = 1'b0;
        scan_base = cyc;
        n = cyc;
        expect_at(n + LAT,     8'hA9, 4'h2, 4'h2);
        expect_at(n + LAT + 1, 8'hA9, 4'h2, 4'h0);
        step(12);
        BTN_raw = 4'h0;
        n = cyc;
        expect_at(n + LAT, 8'hA9, 4'h0, 4'h0);
        step(12);

        // Simultaneous change on SW[7:5] and all buttons.
        SW_raw  = 8'h49;
        BTN_raw = 4'hF;
        n = cyc;
        expect_at(n + LAT,     8'h49, 4'hF, 4'hF);
        expect_at(n + LAT + 1, 8'h49, 4'hF, 4'h0);
        step(12);
        BTN_raw = 4'h0;
        n = cyc;
        expect_at(n + LAT, 8'h49, 4'h0, 4'h0);

        for (int t = 0; t < 20 && evq.size() != 0; t++) step(1);
        step(2);
        chk("queue_drained", 32'(evq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
